// File: rtl/morse_pkg.sv
// Shared Morse symbol codes, element lengths and keyer FSM states.
package morse_pkg;

  // Symbol codes, same encoding as the receiver's ditsdahs output.
  localparam logic [2:0] SYM_WAIT  = 3'd0;
  localparam logic [2:0] SYM_DIT   = 3'd1;
  localparam logic [2:0] SYM_DAH   = 3'd2;
  localparam logic [2:0] SYM_GAP   = 3'd3;
  localparam logic [2:0] SYM_SPACE = 3'd4;

  // Element lengths in Morse time units.
  localparam logic [2:0] DIT_LEN      = 3'd1;
  localparam logic [2:0] DAH_LEN      = 3'd3;
  localparam logic [2:0] ELEM_GAP     = 3'd1;
  localparam logic [2:0] LETTER_EXTRA = 3'd2;
  localparam logic [2:0] WORD_EXTRA   = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE
  } keyer_state_e;

  // Only real keying symbols take up a FIFO slot.
  function automatic logic sym_storable(input logic [2:0] s);
    return (s >= SYM_DIT) && (s <= SYM_SPACE);
  endfunction

endpackage

// File: rtl/morse_sym_fifo.sv
// Small synchronous FIFO for symbol codes; wrap bit on the pointers
// separates full from empty.
module morse_sym_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             bigclk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance and storage write for the next cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // FIFO state; reset empties it immediately.
  always_ff @(posedge bigclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// Morse transmitter: symbol FIFO feeding a mark/space timing FSM with a
// registered key output.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int UNIT_CYCLES = 1
) (
  input  logic       bigclk,
  input  logic       reset_n,
  input  logic [2:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       signal,
  output logic       busy
);

  localparam int             UW        = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UW-1:0]  UNIT_LAST = UW'(UNIT_CYCLES - 1);

  keyer_state_e  state_q, state_d;
  logic [2:0]    len_q, len_d;
  logic [UW-1:0] unit_q, unit_d;
  logic          signal_q, signal_d;
  logic          busy_q, busy_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2:0]    fifo_dout;
  logic          unit_last, elem_done, load;

  // Codes outside DIT..SPACE are handshaken and silently dropped.
  assign sym_ready = !fifo_full;
  assign fifo_push = sym_valid && sym_ready && sym_storable(sym_in);

  morse_sym_fifo #(.DEPTH(DEPTH), .WIDTH(3)) u_fifo (
    .bigclk  (bigclk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (sym_in),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign unit_last = (unit_q == UNIT_LAST);
  assign elem_done = unit_last && (len_q == 3'd1);

  // Next state: count units down, chain straight into the next symbol
  // from the last space cycle so back-to-back symbols have no dead cycle.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    unit_d   = unit_q;
    fifo_pop = 1'b0;
    load     = 1'b0;

    if (state_q != ST_IDLE && !elem_done) begin
      if (unit_last) begin
        unit_d = '0;
        len_d  = len_q - 3'd1;
      end else begin
        unit_d = unit_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE:  if (!fifo_empty) load = 1'b1;
      ST_MARK:  if (elem_done) begin
                  state_d = ST_SPACE;
                  len_d   = ELEM_GAP;
                  unit_d  = '0;
                end
      ST_SPACE: if (elem_done) begin
                  if (!fifo_empty) load = 1'b1;
                  else begin
                    state_d = ST_IDLE;
                    len_d   = '0;
                    unit_d  = '0;
                  end
                end
      default:  state_d = ST_IDLE;
    endcase

    if (load) begin
      fifo_pop = 1'b1;
      unit_d   = '0;
      case (fifo_dout)
        SYM_DIT: begin state_d = ST_MARK;  len_d = DIT_LEN;      end
        SYM_DAH: begin state_d = ST_MARK;  len_d = DAH_LEN;      end
        SYM_GAP: begin state_d = ST_SPACE; len_d = LETTER_EXTRA; end
        default: begin state_d = ST_SPACE; len_d = WORD_EXTRA;   end
      endcase
    end
  end

  // Output register lags the FSM by one cycle, giving the 2-cycle latency.
  always_comb begin
    signal_d = (state_q == ST_MARK);
    busy_d   = (state_q != ST_IDLE) || !fifo_empty;
  end

  // FSM, counters and output registers; reset silences the key at once.
  always_ff @(posedge bigclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      unit_q   <= '0;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      unit_q   <= unit_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
    end
  end

  assign signal = signal_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer: expected key waveform is expanded from
// each accepted symbol into a queue and popped one sample per cycle.
module tb_morse_keyer;

  logic       bigclk = 1'b0;
  logic       reset_n;
  logic [2:0] sym_in1, sym_in3;
  logic       v1, v3;
  logic       r1, r3, s1, s3, b1, b3;

  int         vecs = 0;
  int         errs = 0;
  logic       exp_q[$];
  logic [2:0] stim_q[$];

  always #5 bigclk = ~bigclk;

  morse_keyer #(.DEPTH(4), .UNIT_CYCLES(1)) dut1 (
    .bigclk(bigclk), .reset_n(reset_n), .sym_in(sym_in1), .sym_valid(v1),
    .sym_ready(r1), .signal(s1), .busy(b1)
  );

  morse_keyer #(.DEPTH(4), .UNIT_CYCLES(3)) dut3 (
    .bigclk(bigclk), .reset_n(reset_n), .sym_in(sym_in3), .sym_valid(v3),
    .sym_ready(r3), .signal(s3), .busy(b3)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge bigclk);
    #1;
  endtask

  task automatic drive(input int sel, input logic [2:0] c, input logic v);
    if (sel == 3) begin sym_in3 = c; v3 = v; end
    else          begin sym_in1 = c; v1 = v; end
  endtask

  // Expand one symbol into its per-cycle key values.
  task automatic add_exp(input int uc, input logic [2:0] c);
    int mark, space;
    mark = 0; space = 0;
    case (c)
      3'd1: begin mark = 1; space = 1; end
      3'd2: begin mark = 3; space = 1; end
      3'd3: space = 2;
      3'd4: space = 6;
      default: ;
    endcase
    for (int i = 0; i < mark * uc; i++)  exp_q.push_back(1'b1);
    for (int i = 0; i < space * uc; i++) exp_q.push_back(1'b0);
  endtask

  // Offer stim_q on one DUT holding valid until accepted; compare signal each
  // cycle. bp_at>0 checks sym_ready low right after that many acceptances.
  task automatic run(input int sel, input string tag, input int bp_at, output int stalls);
    int idx, cyc, start, acc;
    logic accept, rdy, sig;
    idx = 0; cyc = 0; start = -1; acc = 0; stalls = 0;
    while ((idx < stim_q.size() || exp_q.size() > 0) && cyc < 400) begin
      if (idx < stim_q.size()) drive(sel, stim_q[idx], 1'b1);
      else                     drive(sel, 3'd0, 1'b0);
      rdy    = (sel == 3) ? r3 : r1;
      accept = (idx < stim_q.size()) && rdy;
      step();
      cyc++;
      if (accept) begin
        if (start < 0 && stim_q[idx] >= 3'd1 && stim_q[idx] <= 3'd4) start = cyc;
        add_exp((sel == 3) ? 3 : 1, stim_q[idx]);
        idx++;
        acc++;
        if (bp_at > 0 && acc == bp_at) chk({tag, " ready_low_when_full"}, r1, 1'b0);
      end else if (idx < stim_q.size()) begin
        stalls++;
      end
      sig = (sel == 3) ? s3 : s1;
      if (start >= 0 && cyc >= start + 2) chk({tag, " signal"}, sig, exp_q.pop_front());
      else                                chk({tag, " signal_pre"}, sig, 1'b0);
    end
    vecs++;
    assert (exp_q.size() == 0 && idx == stim_q.size()) else begin
      errs++;
      $error("FAIL %s timeout: pending %0d sent %0d", tag, exp_q.size(), idx);
    end
    drive(sel, 3'd0, 1'b0);
    step();
    chk({tag, " busy_end"},  (sel == 3) ? b3 : b1, 1'b0);
    chk({tag, " ready_end"}, (sel == 3) ? r3 : r1, 1'b1);
    chk({tag, " signal_end"}, (sel == 3) ? s3 : s1, 1'b0);
    stim_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int stalls;
    reset_n = 1'b0;
    sym_in1 = '0; sym_in3 = '0; v1 = 1'b0; v3 = 1'b0;
    #1;
    chk("reset signal", s1, 1'b0);
    chk("reset busy",   b1, 1'b0);
    chk("reset ready",  r1, 1'b1);
    chk("reset signal3", s3, 1'b0);
    #12 reset_n = 1'b1;
    step();

    // Single DIT with explicit latency and busy timing.
    drive(1, 3'd1, 1'b1);
    step();                                 // edge 0: accepted
    drive(1, 3'd0, 1'b0);
    chk("dit e0 signal", s1, 1'b0);
    chk("dit e0 busy",   b1, 1'b0);
    step();                                 // edge 1: popped, FSM in MARK
    chk("dit e1 signal", s1, 1'b0);
    chk("dit e1 busy",   b1, 1'b1);
    step();
    chk("dit e2 signal", s1, 1'b1);
    step();
    chk("dit e3 signal", s1, 1'b0);
    chk("dit e3 busy",   b1, 1'b1);
    step();
    chk("dit e4 busy",   b1, 1'b0);
    chk("dit e4 signal", s1, 1'b0);

    // DAH then GAP: 1,1,1,0,0,0 contiguous.
    stim_q = '{3'd2, 3'd3};
    run(1, "dah_gap", 0, stalls);

    // Word gap: DIT, SPACE, DIT.
    stim_q = '{3'd1, 3'd4, 3'd1};
    run(1, "word", 0, stalls);

    // Loopback letter: DIT, DAH, GAP.
    stim_q = '{3'd1, 3'd2, 3'd3};
    run(1, "loop", 0, stalls);

    // Backpressure: a leading SPACE holds the FSM so 4 DITs fill the FIFO.
    stim_q = '{3'd4, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    run(1, "bp", 5, stalls);
    vecs++;
    assert (stalls > 0) else begin
      errs++;
      $error("FAIL bp stall: observed %0d stall cycles expected >0", stalls);
    end

    // Filtering and unit stretch on the UNIT_CYCLES=3 instance.
    stim_q = '{3'd0, 3'd6, 3'd2};
    run(3, "filt", 0, stalls);

    // Reset during the 2nd mark cycle of a DAH with a DIT queued behind it.
    drive(1, 3'd2, 1'b1);
    step();
    drive(1, 3'd1, 1'b1);
    step();
    drive(1, 3'd0, 1'b0);
    step();
    chk("rst mark1", s1, 1'b1);
    step();
    chk("rst mark2", s1, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst async signal", s1, 1'b0);
    chk("rst async busy",   b1, 1'b0);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rst after signal", s1, 1'b0);
      chk("rst after busy",   b1, 1'b0);
    end

    // First write right after reset release.
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    stim_q = '{3'd1, 3'd4, 3'd1};
    run(1, "post_rst", 0, stalls);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
